// File: rtl/read_part_pkg.sv
// Shared FIFO constants: default geometry for the read-domain half of the async FIFO.
package read_part_pkg;
  localparam int unsigned FIFO_WIDTH_A     = 8;
  localparam int unsigned FIFO_WIDTH_D     = 8;
  localparam int unsigned FIFO_SYNC_STAGES = 2;
  localparam int unsigned FIFO_AE_LEVEL    = 2;
endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray conversion.
module bin_to_gray #(
  parameter int unsigned WIDTH_D = 4
) (
  input  logic [WIDTH_D-1:0] bin,
  output logic [WIDTH_D-1:0] gray
);
  always_comb gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module gray_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  always_comb dout = chain[STAGES-1];
endmodule

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int unsigned WIDTH_D = 4
) (
  input  logic [WIDTH_D-1:0] gray,
  output logic [WIDTH_D-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH_D; i++) bin[i] = ^(gray >> i);
  end
endmodule

// File: rtl/read_part.sv
// Read-domain half of the async FIFO: read pointer, write-pointer sync, empty/level flags,
// and a 2-entry first-word-fall-through output buffer fed by a 1-cycle-latency RAM.
module read_part
  import read_part_pkg::*;
#(
  parameter int unsigned WIDTH_A     = FIFO_WIDTH_A,
  parameter int unsigned WIDTH_D     = FIFO_WIDTH_D,
  parameter int unsigned SYNC_STAGES = FIFO_SYNC_STAGES,
  parameter int unsigned AE_LEVEL    = FIFO_AE_LEVEL
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               r_req,
  input  logic [WIDTH_A:0]   w_gaddr,
  input  logic [WIDTH_D-1:0] mem_rdata,
  output logic               mem_ren,
  output logic [WIDTH_A:0]   r_addr,
  output logic [WIDTH_A:0]   r_gaddr,
  output logic [WIDTH_D-1:0] r_data,
  output logic               r_valid,
  output logic               r_empty,
  output logic               r_almost_empty,
  output logic [WIDTH_A+1:0] r_level
);
  localparam int unsigned PW = WIDTH_A + 1;
  localparam logic [WIDTH_A+1:0] AE_LVL = (WIDTH_A+2)'(AE_LEVEL);

  logic [PW-1:0]      wg_s, wb_s, r_addr_inc, r_gaddr_inc, ptr_diff;
  logic               inflight, pop, mem_empty;
  logic [1:0]         occ;
  logic [2:0]         occ_next;
  logic [WIDTH_D-1:0] buf_q [2];
  logic               head, tail;

  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (r_clk),
    .rst_n (r_rst),
    .din   (w_gaddr),
    .dout  (wg_s)
  );

  gray_to_bin #(.WIDTH_D(PW)) u_g2b (
    .gray (wg_s),
    .bin  (wb_s)
  );

  bin_to_gray #(.WIDTH_D(PW)) u_b2g (
    .bin  (r_addr_inc),
    .gray (r_gaddr_inc)
  );

  // Issue a RAM read only if the buffer still has room after everything already committed lands.
  always_comb begin
    r_addr_inc = r_addr + PW'(1);
    mem_empty  = (r_gaddr == wg_s);
    r_valid    = (occ != 2'd0);
    r_empty    = !r_valid;
    pop        = r_valid && r_req;
    occ_next   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    mem_ren    = !mem_empty && (occ_next <= 3'd1);
    r_data     = buf_q[head];
    ptr_diff   = wb_s - r_addr;
    r_level    = {1'b0, ptr_diff} + (WIDTH_A+2)'(inflight) + (WIDTH_A+2)'(occ);
    r_almost_empty = (r_level <= AE_LVL);
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_addr   <= '0;
      r_gaddr  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_ren;
      if (mem_ren) begin
        r_addr  <= r_addr_inc;
        r_gaddr <= r_gaddr_inc;
      end
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      occ      <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      if (inflight) begin
        buf_q[tail] <= mem_rdata;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ_next[1:0];
    end
  end
endmodule
